dcache_mem_seq: RTL and testbench
=================================

// Module: dcache_mem_seq
// PURPOSE
//  Memory-side sequencer for the data cache. Turns a line push (writeback) or pull (fill) request into a QPI-style nibble-serial transaction on the shared external memory bus.
//  Streams line nibbles out of / into the cache via contiguous rstrobe_d / wstrobe_d bursts.
//  Arbitrates for the bus with bus_req/bus_gnt; sits between the dcache and the memory bus mux.
// PARAMETERS
//  PA            22     physical address width (byte address)
//  LINE_LENGTH   4      cache line bytes; transfer = 2*LINE_LENGTH nibbles
//  DUMMY_CYCLES  4      turnaround nibbles between address and read data
//  CS_GAP        1      minimum cycles mem_cs held low between transactions
// PORTS
//  clk        in   1                 clock
//  reset      in   1                 reset, synchronous, active-high
//  push       in   1                 cache requests line writeback
//  pull       in   1                 cache requests line fill
//  tag        in   PA-log2(LL)       line address ([PA-1:log2(LINE_LENGTH)])
//  dwrite     in   4                 writeback nibble from cache (valid in rstrobe_d cycle)
//  rstrobe_d  out  1                 cache: writeback nibble consumed, advance
//  dread      out  4                 fill nibble to cache
//  wstrobe_d  out  1                 cache: dread valid, store and advance
//  busy       out  1                 transaction in progress (IDLE excluded)
//  bus_req    out  1                 request shared memory bus
//  bus_gnt    in   1                 bus granted (held while bus_req high)
//  mem_cs     out  1                 chip select, active-high
//  mem_oe     out  1                 drive mem_dout onto pads
//  mem_dout   out  4                 nibble out (registered)
//  mem_din    in   4                 nibble in
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; nibble counter 0.
//  FSM: IDLE->REQ->CMD(2)->ADDR(6)->{WDATA(2*LL)->WTAIL(1) | DUMMY(DUMMY_CYCLES)->RDATA(2*LL)}->GAP(CS_GAP)->IDLE.
//  IDLE: push has priority over pull; latch op, tag. Requests ignored while busy.
//  REQ: bus_req=1; wait for bus_gnt; bus_req stays 1 until leaving GAP.
//  CMD: mem_cs=1,mem_oe=1; send 8'h38 (write) or 8'hEB (read), high nibble first.
//  ADDR: 24-bit byte address {zero-ext tag, log2(LL)'b0}, 6 nibbles, MS nibble first.
//  WDATA: rstrobe_d=1 for exactly 2*LL consecutive cycles; mem_dout<=dwrite next cycle.
//  WTAIL: last nibble on bus; then mem_cs=0.
//  DUMMY: mem_oe=0, mem_cs=1, DUMMY_CYCLES cycles.
//  RDATA: dread=mem_din; wstrobe_d=1 for exactly 2*LL consecutive cycles.
//  Strobes never gap mid-burst: cache offset counter restarts on any gap.
//  Nibble order is passthrough: the cache owns the within-byte nibble swap.
//  GAP: mem_cs=0, mem_oe=0 for CS_GAP cycles; push then pull (dirty miss) costs two full transactions.
//  Reset mid-transaction: next cycle mem_cs/mem_oe/strobes/bus_req=0, IDLE; the cache line is left partial, and the cache invalidates on reset.
//  bus_gnt dropping after grant is a protocol error, undefined.
//  Read latency (IDLE push/pull to first wstrobe_d, gnt immediate): 1+1+2+6+DUMMY_CYCLES cycles.
// CONFIGURATION
//  DCMEM_INPUT_REG_EN defined:
//   - mem_din registered before dread.
//   - RDATA begins one cycle after DUMMY ends; wstrobe_d aligns with registered data.
//   - mem_cs held one extra cycle; read latency +1.
//  Undefined: dread combinational from mem_din; no extra cycle.
// STRUCTURE
//  Package dcache_mem_pkg:
//   - state enum
//   - CMD_WRITE=8'h38, CMD_READ=8'hEB
//   - ADDR_NIBBLES=6, CMD_NIBBLES=2
//   - address-to-nibble function
//  Sub-module dcmem_tx_shift: parallel-load 32-bit shift register (cmd+addr), 1 nibble/cycle MS first.
// TESTING
//  pull, tag=0x12345 (PA=22, LL=4), gnt immediate:
//   - mem_dout 3,8 (0x38? no: E,B) then 0,4,8,D,1,4 (byte addr 0x048D14)
//   - 4 dummy; 8 wstrobe_d cycles carry mem_din 1..8
//  push, dwrite 0xA..0x3 over 8 cycles:
//   - mem_dout 3,8, address nibbles, then A..3 each one cycle after its rstrobe_d
//   - WTAIL; mem_cs low
//  push+pull same cycle:
//   - write transaction, CS_GAP low, then read transaction
//   - bus_req low >=1 cycle between
//  bus_gnt held 0 for 5 cycles: mem_cs stays 0, no strobes; CMD starts cycle after gnt.
//  reset asserted in RDATA after 3 wstrobe_d: next cycle all outputs 0; new pull restarts at REQ.
//  DCMEM_INPUT_REG_EN build: first-wstrobe latency exactly +1 vs default; data still 1..8.
```

Correction to the first TESTING scenario: the expected command nibbles for a pull are E,B (CMD_READ=8'hEB), not 3,8. Those are followed by 0,4,8,D,1,4.

Source files
------------

// File: rtl/dcache_mem_pkg.sv
// Shared states, bus command codes and the command/address nibble stream builder
// for the dcache memory-side sequencer.
package dcache_mem_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_WTAIL,
        S_DUMMY,
        S_RDATA,
        S_GAP
    } state_e;

    localparam logic [7:0]  CMD_WRITE    = 8'h38;
    localparam logic [7:0]  CMD_READ     = 8'hEB;
    localparam int unsigned CMD_NIBBLES  = 2;
    localparam int unsigned ADDR_NIBBLES = 6;
    localparam int unsigned TX_W         = 4 * (CMD_NIBBLES + ADDR_NIBBLES);

    // Command byte followed by the byte address, laid out MS nibble first as sent on the bus.
    function automatic logic [TX_W-1:0] tx_nibbles(input logic is_read,
                                                   input logic [4*ADDR_NIBBLES-1:0] byte_addr);
        return {(is_read ? CMD_READ : CMD_WRITE), byte_addr};
    endfunction

endpackage

// File: rtl/dcmem_tx_shift.sv
// Parallel-load shift register for the command + address phase; presents the
// most significant nibble and advances one nibble per shift.
module dcmem_tx_shift
    import dcache_mem_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            shift_i,
    input  logic [TX_W-1:0] data_i,
    output logic [3:0]      nib_o
);

    logic [TX_W-1:0] sr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= data_i;
        end else if (shift_i) begin
            sr_q <= {sr_q[TX_W-5:0], 4'h0};
        end
    end

    assign nib_o = sr_q[TX_W-1 -: 4];

endmodule

// File: rtl/dcache_mem_seq.sv
// Memory-side sequencer: turns a line push/pull into a nibble-serial bus transaction.
// Define DCMEM_INPUT_REG_EN to register mem_din before dread (one extra read cycle).
module dcache_mem_seq
    import dcache_mem_pkg::*;
#(
    parameter int unsigned PA           = 22,
    parameter int unsigned LINE_LENGTH  = 4,
    parameter int unsigned DUMMY_CYCLES = 4,
    parameter int unsigned CS_GAP       = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push,
    input  logic                             pull,
    input  logic [PA-1:$clog2(LINE_LENGTH)]  tag,
    input  logic [3:0]                       dwrite,
    output logic                             rstrobe_d,
    output logic [3:0]                       dread,
    output logic                             wstrobe_d,
    output logic                             busy,
    output logic                             bus_req,
    input  logic                             bus_gnt,
    output logic                             mem_cs,
    output logic                             mem_oe,
    output logic [3:0]                       mem_dout,
    input  logic [3:0]                       mem_din
);

    localparam int unsigned OFF_BITS  = $clog2(LINE_LENGTH);
    localparam int unsigned AW        = 4 * ADDR_NIBBLES;
    localparam int unsigned DATA_NIBS = 2 * LINE_LENGTH;
`ifdef DCMEM_INPUT_REG_EN
    localparam int unsigned DUMMY_LEN = DUMMY_CYCLES + 1;
`else
    localparam int unsigned DUMMY_LEN = DUMMY_CYCLES;
`endif
    localparam int unsigned CNT_W = $clog2(DATA_NIBS + DUMMY_LEN + CS_GAP + ADDR_NIBBLES + 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             is_read_q;
    logic             bus_req_q, cs_q, oe_q, rstrobe_q, wstrobe_q;
    logic [3:0]       dout_q;

    logic [AW-1:0]    byte_addr;
    logic             accept, sh_shift;
    logic [3:0]       sh_nib;

    assign byte_addr = AW'({tag, {OFF_BITS{1'b0}}});
    assign accept    = (state_q == S_IDLE) && (push || pull);
    // The first nibble leaves on the grant edge, the last address nibble is already on the bus in ADDR's final cycle.
    assign sh_shift  = ((state_q == S_REQ) && bus_gnt) || (state_q == S_CMD) ||
                       ((state_q == S_ADDR) && (cnt_q != CNT_W'(ADDR_NIBBLES - 1)));

    dcmem_tx_shift u_tx_shift (
        .clk     (clk),
        .reset   (reset),
        .load_i  (accept),
        .shift_i (sh_shift),
        .data_i  (tx_nibbles(!push, byte_addr)),
        .nib_o   (sh_nib)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_read_q <= 1'b0;
            bus_req_q <= 1'b0;
            cs_q      <= 1'b0;
            oe_q      <= 1'b0;
            rstrobe_q <= 1'b0;
            wstrobe_q <= 1'b0;
            dout_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    is_read_q <= !push;
                    bus_req_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= S_REQ;
                end
                S_REQ: if (bus_gnt) begin
                    cs_q    <= 1'b1;
                    oe_q    <= 1'b1;
                    dout_q  <= sh_nib;
                    cnt_q   <= '0;
                    state_q <= S_CMD;
                end
                S_CMD: begin
                    dout_q <= sh_nib;
                    if (cnt_q == CNT_W'(CMD_NIBBLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_ADDR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_ADDR: begin
                    if (cnt_q == CNT_W'(ADDR_NIBBLES - 1)) begin
                        cnt_q <= '0;
                        if (is_read_q) begin
                            oe_q    <= 1'b0;
                            state_q <= S_DUMMY;
                        end else begin
                            rstrobe_q <= 1'b1;
                            state_q   <= S_WDATA;
                        end
                    end else begin
                        dout_q <= sh_nib;
                        cnt_q  <= cnt_q + 1'b1;
                    end
                end
                S_WDATA: begin
                    dout_q <= dwrite;
                    if (cnt_q == CNT_W'(DATA_NIBS - 1)) begin
                        rstrobe_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= S_WTAIL;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WTAIL: begin
                    cs_q    <= 1'b0;
                    oe_q    <= 1'b0;
                    state_q <= S_GAP;
                end
                S_DUMMY: begin
                    if (cnt_q == CNT_W'(DUMMY_LEN - 1)) begin
                        wstrobe_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= S_RDATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RDATA: begin
                    if (cnt_q == CNT_W'(DATA_NIBS - 1)) begin
                        wstrobe_q <= 1'b0;
                        cs_q      <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= S_GAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == CNT_W'(CS_GAP - 1)) begin
                        bus_req_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef DCMEM_INPUT_REG_EN
    logic [3:0] din_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            din_q <= '0;
        end else begin
            din_q <= mem_din;
        end
    end

    assign dread = wstrobe_q ? din_q : '0;
`else
    assign dread = wstrobe_q ? mem_din : '0;
`endif

    assign busy      = (state_q != S_IDLE);
    assign bus_req   = bus_req_q;
    assign mem_cs    = cs_q;
    assign mem_oe    = oe_q;
    assign mem_dout  = dout_q;
    assign rstrobe_d = rstrobe_q;
    assign wstrobe_d = wstrobe_q;

endmodule

// File: tb/tb_dcache_mem_seq.sv
// Self-checking bench for dcache_mem_seq: bus-level memory/cache/arbiter models feed a
// per-cycle history that is checked against transaction-level expectations.
module tb_dcache_mem_seq;

    localparam int PA   = 22;
    localparam int LL   = 4;
    localparam int DUM  = 4;
    localparam int GAPC = 1;
    localparam int TW   = 20;
    localparam int NIB  = 2 * LL;
`ifdef DCMEM_INPUT_REG_EN
    localparam int REG = 1;
`else
    localparam int REG = 0;
`endif

    logic          clk;
    logic          reset, push, pull, bus_gnt;
    logic [TW-1:0] tag;
    logic [3:0]    dwrite, mem_din;
    logic          rstrobe_d, wstrobe_d, busy, bus_req, mem_cs, mem_oe;
    logic [3:0]    dread, mem_dout;

    dcache_mem_seq #(
        .PA           (PA),
        .LINE_LENGTH  (LL),
        .DUMMY_CYCLES (DUM),
        .CS_GAP       (GAPC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pull      (pull),
        .tag       (tag),
        .dwrite    (dwrite),
        .rstrobe_d (rstrobe_d),
        .dread     (dread),
        .wstrobe_d (wstrobe_d),
        .busy      (busy),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .mem_cs    (mem_cs),
        .mem_oe    (mem_oe),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = -1;
    int         cs_pos, wb_idx, gnt_hold;
    logic [7:0] mcmd;
    bit         rs_prev;
    logic [3:0] wb_data [NIB];
    logic [3:0] rd_data [NIB];

    bit         h_cs[$], h_oe[$], h_breq[$], h_busy[$], h_rs[$], h_ws[$];
    logic [3:0] h_dout[$], h_dread[$];

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    // One clock: memory, cache and arbiter react on the falling edge, then the cycle is logged.
    task automatic tick();
        @(negedge clk);
        if (mem_cs) begin
            if (cs_pos == 0) mcmd = {mem_dout, 4'h0};
            if (cs_pos == 1) mcmd[3:0] = mem_dout;
            if (mcmd == 8'hEB && cs_pos >= 8 + DUM && cs_pos < 8 + DUM + NIB)
                mem_din = rd_data[cs_pos - 8 - DUM];
            else
                mem_din = 4'($urandom);
            cs_pos++;
        end else begin
            cs_pos  = 0;
            mem_din = 4'($urandom);
        end
        if (rstrobe_d) begin
            if (!rs_prev) wb_idx = 0;
            dwrite = (wb_idx < NIB) ? wb_data[wb_idx] : 4'($urandom);
            wb_idx++;
        end else begin
            dwrite = 4'($urandom);
        end
        rs_prev = rstrobe_d;
        if (bus_req && gnt_hold > 0) begin
            bus_gnt = 1'b0;
            gnt_hold--;
        end else begin
            bus_gnt = bus_req;
        end
        #1;
        h_cs.push_back(mem_cs);
        h_oe.push_back(mem_oe);
        h_breq.push_back(bus_req);
        h_busy.push_back(busy);
        h_rs.push_back(rstrobe_d);
        h_ws.push_back(wstrobe_d);
        h_dout.push_back(mem_dout);
        h_dread.push_back(dread);
        cyc = h_cs.size() - 1;
    endtask

    task automatic wait_idle();
        bit seen = 0;
        int n = 0;
        while (n < 400) begin
            if (busy) seen = 1;
            else if (seen) break;
            tick();
            n++;
        end
        chk("idle_timeout", 32'(n < 400), 32'd1);
    endtask

    // Expected shape of one transaction requested in cycle req_c, derived from the bus protocol.
    task automatic check_txn(input int req_c, input bit rd, input logic [TW-1:0] t,
                             input int gd, output int idle_c);
        int          cs0, cs1, first, last, n, last_i;
        logic [31:0] word;
        word = {(rd ? 8'hEB : 8'h38), 24'({t, 2'b00})};
        cs0 = req_c;
        for (int i = req_c; i < h_cs.size(); i++)
            if (h_cs[i]) begin cs0 = i; break; end
        chk("cs_start", 32'(cs0), 32'(req_c + 2 + gd));
        cs1 = cs0;
        while (cs1 + 1 < h_cs.size() && h_cs[cs1 + 1]) cs1++;
        chk("cs_len", 32'(cs1 - cs0 + 1), 32'(rd ? 8 + DUM + NIB + REG : 8 + 1 + NIB));
        for (int k = 0; k < 8; k++) begin
            chk("cmd_addr_nib", 32'(h_dout[cs0 + k]), 32'(word[31 - 4*k -: 4]));
            chk("oe_cmd_addr", 32'(h_oe[cs0 + k]), 32'd1);
        end
        last_i = cs1 + GAPC + 1;
        n = 0; first = -1; last = -1;
        for (int i = req_c; i <= last_i && i < h_cs.size(); i++) begin
            if (rd ? h_ws[i] : h_rs[i]) begin
                if (first < 0) first = i;
                last = i;
                if (rd && n < NIB) chk("dread", 32'(h_dread[i]), 32'(rd_data[n]));
                n++;
            end
            if (rd ? h_rs[i] : h_ws[i]) chk("wrong_strobe", 32'd1, 32'd0);
        end
        chk("strobe_count", 32'(n), 32'(NIB));
        chk("strobe_contig", 32'(last - first), 32'(NIB - 1));
        if (rd) begin
            chk("read_latency", 32'(first - req_c), 32'(1 + 1 + 2 + 6 + DUM + REG + gd));
            chk("oe_dummy", 32'(h_oe[cs0 + 8]), 32'd0);
        end else begin
            chk("rstrobe_start", 32'(first), 32'(cs0 + 8));
            for (int k = 0; k < NIB; k++)
                chk("wdata_nib", 32'(h_dout[cs0 + 9 + k]), 32'(wb_data[k]));
            chk("oe_wtail", 32'(h_oe[cs1]), 32'd1);
        end
        chk("breq_before", 32'(h_breq[req_c]), 32'd0);
        chk("breq_req", 32'(h_breq[req_c + 1]), 32'd1);
        chk("breq_gap", 32'(h_breq[cs1 + GAPC]), 32'd1);
        chk("breq_idle", 32'(h_breq[last_i]), 32'd0);
        chk("busy_idle", 32'(h_busy[last_i]), 32'd0);
        idle_c = last_i;
    endtask

    task automatic txn(input bit rd, input logic [TW-1:0] t, input int gd);
        int rc, ic;
        gnt_hold = gd;
        tick();
        tag  = t;
        push = !rd;
        pull = rd;
        rc   = cyc;
        tick();
        push = 1'b0;
        pull = 1'b0;
        wait_idle();
        check_txn(rc, rd, t, gd, ic);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_cs"},      32'(mem_cs),    32'd0);
        chk({name, "_oe"},      32'(mem_oe),    32'd0);
        chk({name, "_dout"},    32'(mem_dout),  32'd0);
        chk({name, "_rstrobe"}, 32'(rstrobe_d), 32'd0);
        chk({name, "_wstrobe"}, 32'(wstrobe_d), 32'd0);
        chk({name, "_dread"},   32'(dread),     32'd0);
        chk({name, "_busreq"},  32'(bus_req),   32'd0);
        chk({name, "_busy"},    32'(busy),      32'd0);
    endtask

    initial begin
        int            rc, ic, e, wsn, n;
        bit            rd;
        logic [TW-1:0] t;

        reset = 1'b1; push = 1'b0; pull = 1'b0; tag = '0; dwrite = '0; mem_din = '0;
        bus_gnt = 1'b0; gnt_hold = 0; cs_pos = 0; mcmd = '0; rs_prev = 0; wb_idx = 0;
        for (int k = 0; k < NIB; k++) begin
            wb_data[k] = '0;
            rd_data[k] = '0;
        end
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        for (int k = 0; k < NIB; k++) rd_data[k] = 4'(k + 1);
        txn(1'b1, 20'h12345, 0);

        for (int k = 0; k < NIB; k++) wb_data[k] = 4'(10 - k);
        txn(1'b0, 20'h0BEEF, 0);

        // Dirty miss: push and pull together, pull held until the read transaction starts.
        for (int k = 0; k < NIB; k++) begin
            wb_data[k] = 4'($urandom);
            rd_data[k] = 4'($urandom);
        end
        t = 20'h5A5A5;
        gnt_hold = 0;
        tick();
        tag = t; push = 1'b1; pull = 1'b1; rc = cyc;
        tick();
        push = 1'b0;
        wait_idle();
        check_txn(rc, 1'b0, t, 0, e);
        tick();
        pull = 1'b0;
        wait_idle();
        check_txn(e, 1'b1, t, 0, ic);

        for (int k = 0; k < NIB; k++) rd_data[k] = 4'(15 - k);
        txn(1'b1, 20'hFFFFF, 5);

        // Reset in the middle of a read burst.
        for (int k = 0; k < NIB; k++) rd_data[k] = 4'($urandom);
        tick();
        tag = 20'h00321; pull = 1'b1;
        tick();
        pull = 1'b0;
        wsn = 0; n = 0;
        while (n < 100) begin
            if (wstrobe_d) wsn++;
            if (wsn == 3) break;
            tick();
            n++;
        end
        chk("rst_reach_3rd_ws", 32'(wsn), 32'd3);
        reset = 1'b1;
        tick();
        check_all_zero("midreset");
        reset = 1'b0;
        txn(1'b1, 20'h00321, 0);

        for (int it = 0; it < 12; it++) begin
            rd = 1'($urandom_range(0, 1));
            t  = 20'($urandom);
            for (int k = 0; k < NIB; k++) begin
                wb_data[k] = 4'($urandom);
                rd_data[k] = 4'($urandom);
            end
            txn(rd, t, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
